// File: rtl/spi_slave_tx.sv
// SPI slave MISO transmit path: oversampled SCLK/CS_N, one-word prefetch hold,
// MSB-first shifter with underrun fill and byte-done/underrun status pulses.
module spi_slave_tx #(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic              CPOL        = 1'b0,
   parameter logic              CPHA        = 1'b0,
   parameter logic [WIDTH-1:0]  IDLE_FILL   = {WIDTH{1'b1}}
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             S_WVALID,
   output logic             S_WREADY,
   input  logic [WIDTH-1:0] S_WDATA,
   input  logic             SPI_CS_N_I,
   input  logic             SPI_SCLK_I,
   output logic             SPI_MISO_O,
   output logic             SPI_MISO_OE_O,
   output logic             BYTE_DONE_O,
   output logic             UNDERRUN_O
);

   localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned FlushW = $clog2(SYNC_STAGES + 2);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StArm    = 2'd1;
   localparam logic [1:0] StShift  = 2'd2;
   localparam logic [1:0] StWaitCs = 2'd3;

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cs_s, sclk_s;
   logic                   cs_fall, cs_rise, lead, trail, shift_edge;

   logic [1:0]        state_q, state_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
   logic              wready_q, miso_q, oe_q, byte_done_q, underrun_q;
   logic              byte_done_d, underrun_d, load, accept;

   assign cs_s       = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
   assign cs_fall    = cs_prev_q & ~cs_s;
   assign cs_rise    = ~cs_prev_q & cs_s;
   assign lead       = (sclk_prev_q == CPOL) & (sclk_s != CPOL);
   assign trail      = (sclk_prev_q != CPOL) & (sclk_s == CPOL);
   assign shift_edge = CPHA ? lead : trail;
   assign accept     = S_WVALID & wready_q;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= {SYNC_STAGES{CPOL}};
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= CPOL;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N_I};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK_I};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      byte_done_d  = 1'b0;
      underrun_d   = 1'b0;
      load         = 1'b0;
      flush_cnt_d  = (flush_cnt_q != '0) ? flush_cnt_q - FlushW'(1) : '0;

      if (accept) begin
         hold_d       = S_WDATA;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            // Until the synchronizers have flushed, a low CS_N means we woke up mid-frame.
            if (flush_cnt_q != '0) begin
               if (!cs_s) state_d = StWaitCs;
            end else if (cs_fall) begin
               if (CPHA) begin
                  state_d = StArm;
               end else begin
                  load    = 1'b1;
                  state_d = StShift;
               end
            end
         end
         StArm: begin
            if (cs_rise) begin
               state_d = StIdle;
            end else if (lead) begin
               load    = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (cs_rise) begin
               state_d = StIdle;
            end else if (shift_edge) begin
               if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                  byte_done_d = 1'b1;
                  load        = 1'b1;
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
         StWaitCs: begin
            if (cs_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         if (hold_valid_q) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
         end else begin
            shreg_d    = IDLE_FILL;
            underrun_d = 1'b1;
         end
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         shreg_q      <= IDLE_FILL;
         bit_cnt_q    <= '0;
         flush_cnt_q  <= FlushW'(SYNC_STAGES + 1);
         wready_q     <= 1'b0;
         miso_q       <= 1'b1;
         oe_q         <= 1'b0;
         byte_done_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         wready_q     <= ~hold_valid_d;
         // MISO idles high outside SHIFT so ARM never shows stale shifter contents.
         miso_q       <= (state_d == StShift) ? shreg_d[WIDTH-1] : 1'b1;
         oe_q         <= (state_d == StArm) || (state_d == StShift);
         byte_done_q  <= byte_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign S_WREADY      = wready_q;
   assign SPI_MISO_O    = miso_q;
   assign SPI_MISO_OE_O = oe_q;
   assign BYTE_DONE_O   = byte_done_q;
   assign UNDERRUN_O    = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a CPOL0/CPHA0 and a CPOL1/CPHA1 instance driven by an SPI
// master model and stream feeders, checked against a word-level queue model.
module tb_spi_slave_tx;

   localparam int         HALF  = 80;
   localparam int         SYNC  = 2;
   localparam logic [7:0] FILL  = 8'hFF;
   localparam logic [1:0] CPOLV = 2'b10;
   localparam logic [1:0] CPHAV = 2'b10;

   logic       clk, rst;
   logic       cs_n [2], sclk [2], wvalid [2], wready [2];
   logic       miso [2], oe [2], bdone [2], urun [2];
   logic [7:0] wdata [2];

   logic [7:0] wbuf [2][128];
   int         wr [2], fd [2], ld [2], n_bd [2], n_ur [2];
   logic       pend [2];
   int         n_chk, n_err;

   spi_slave_tx #(.WIDTH(8), .SYNC_STAGES(SYNC), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
      .CLK_I(clk), .RST_I(rst), .S_WVALID(wvalid[0]), .S_WREADY(wready[0]),
      .S_WDATA(wdata[0]), .SPI_CS_N_I(cs_n[0]), .SPI_SCLK_I(sclk[0]),
      .SPI_MISO_O(miso[0]), .SPI_MISO_OE_O(oe[0]), .BYTE_DONE_O(bdone[0]),
      .UNDERRUN_O(urun[0])
   );

   spi_slave_tx #(.WIDTH(8), .SYNC_STAGES(SYNC), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
      .CLK_I(clk), .RST_I(rst), .S_WVALID(wvalid[1]), .S_WREADY(wready[1]),
      .S_WDATA(wdata[1]), .SPI_CS_N_I(cs_n[1]), .SPI_SCLK_I(sclk[1]),
      .SPI_MISO_O(miso[1]), .SPI_MISO_OE_O(oe[1]), .BYTE_DONE_O(bdone[1]),
      .UNDERRUN_O(urun[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stream feeders and pulse counters, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (bdone[k] === 1'b1) n_bd[k]++;
         if (urun[k] === 1'b1) n_ur[k]++;
         if (rst) begin
            wvalid[k] = 1'b0;
            pend[k]   = 1'b0;
         end else begin
            if (pend[k]) fd[k]++;
            wvalid[k] = (fd[k] < wr[k]);
            wdata[k]  = (fd[k] < wr[k]) ? wbuf[k][fd[k]] : 8'h00;
            pend[k]   = wvalid[k] && wready[k];
         end
      end
   end

   task automatic push(input int k, input logic [7:0] v);
      wbuf[k][wr[k]] = v;
      wr[k]++;
   endtask

   // One CS_N frame of nbits SCLK periods; the model decides which word each load takes.
   task automatic run_frame(input int k, input int nbits);
      logic [7:0] slot [8];
      int         nloads, exp_ur, exp_bd, bd0, ur0;
      logic       first_fill;
      #(HALF);
      bd0    = n_bd[k];
      ur0    = n_ur[k];
      nloads = (CPHAV[k] == 1'b0) ? 1 + nbits / 8 : (nbits + 7) / 8;
      exp_bd = (CPHAV[k] == 1'b0) ? nbits / 8 : ((nbits == 0) ? 0 : (nbits - 1) / 8);
      exp_ur = 0;
      for (int j = 0; j < nloads; j++) begin
         if (ld[k] < wr[k]) begin
            slot[j] = wbuf[k][ld[k]];
            ld[k]++;
         end else begin
            slot[j] = FILL;
            exp_ur++;
         end
      end
      first_fill = (slot[0] == FILL) && (exp_ur > 0);
      cs_n[k] = 1'b0;
      #(HALF);
      check_eq("oe_frame", 32'(oe[k]), 32'd1);
      if (CPHAV[k] == 1'b0) begin
         check_eq("ur_at_fall", 32'(n_ur[k] - ur0), 32'(first_fill));
      end else begin
         check_eq("miso_pre_lead", 32'(miso[k]), 32'd1);
      end
      for (int i = 0; i < nbits; i++) begin
         if (CPHAV[k] == 1'b0) check_eq("miso_bit", 32'(miso[k]), 32'(slot[i/8][7 - i%8]));
         sclk[k] = ~CPOLV[k];
         #(HALF);
         if (CPHAV[k] == 1'b1) check_eq("miso_bit", 32'(miso[k]), 32'(slot[i/8][7 - i%8]));
         sclk[k] = CPOLV[k];
         #(HALF);
      end
      cs_n[k] = 1'b1;
      #((SYNC + 3) * 10);
      check_eq("oe_after_cs", 32'(oe[k]), 32'd0);
      #(HALF);
      check_eq("byte_done_cnt", 32'(n_bd[k] - bd0), 32'(exp_bd));
      check_eq("underrun_cnt", 32'(n_ur[k] - ur0), 32'(exp_ur));
      check_eq("wready_end", 32'(wready[k]), 32'(ld[k] >= wr[k]));
   endtask

   initial begin
      int bd0, ur0, k, npush, nbits;
      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < 2; i++) begin
         cs_n[i] = 1'b1;
         sclk[i] = CPOLV[i];
         wr[i] = 0; fd[i] = 0; ld[i] = 0; n_bd[i] = 0; n_ur[i] = 0;
         pend[i] = 1'b0; wvalid[i] = 1'b0; wdata[i] = 8'h00;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_miso", 32'(miso[i]), 32'd1);
         check_eq("rst_oe", 32'(oe[i]), 32'd0);
         check_eq("rst_wready", 32'(wready[i]), 32'd0);
         check_eq("rst_bdone", 32'(bdone[i]), 32'd0);
         check_eq("rst_urun", 32'(urun[i]), 32'd0);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("wready_idle", 32'(wready[0]), 32'd1);

      push(0, 8'hA5); push(0, 8'h3C);
      run_frame(0, 16);
      run_frame(0, 8);
      for (int v = 0; v < 4; v++) push(0, 8'(v));
      run_frame(0, 32);
      push(0, 8'h96); push(0, 8'h55);
      run_frame(0, 3);
      run_frame(0, 8);
      push(1, 8'hC3);
      run_frame(1, 8);
      push(1, 8'h5A); push(1, 8'h0F);
      run_frame(1, 16);

      // SCLK activity with CS_N high must not move anything.
      bd0 = n_bd[0];
      ur0 = n_ur[0];
      for (int i = 0; i < 8; i++) begin
         sclk[0] = 1'b1; #(HALF);
         check_eq("idle_sclk_oe", 32'(oe[0]), 32'd0);
         sclk[0] = 1'b0; #(HALF);
      end
      check_eq("idle_sclk_pulses", 32'(n_bd[0] - bd0 + n_ur[0] - ur0), 32'd0);

      // Reset mid-word with CS_N held low; queued data is lost.
      push(0, 8'h11); push(0, 8'h22);
      #(HALF);
      cs_n[0] = 1'b0;
      #(HALF);
      for (int i = 0; i < 3; i++) begin
         sclk[0] = 1'b1; #(HALF);
         sclk[0] = 1'b0; #(HALF);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_oe", 32'(oe[0]), 32'd0);
      check_eq("midrst_miso", 32'(miso[0]), 32'd1);
      check_eq("midrst_wready", 32'(wready[0]), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         fd[i] = wr[i];
         ld[i] = wr[i];
      end
      rst = 1'b0;
      bd0 = n_bd[0];
      ur0 = n_ur[0];
      for (int i = 0; i < 8; i++) begin
         sclk[0] = 1'b1; #(HALF);
         check_eq("postrst_oe", 32'(oe[0]), 32'd0);
         check_eq("postrst_miso", 32'(miso[0]), 32'd1);
         sclk[0] = 1'b0; #(HALF);
      end
      check_eq("postrst_pulses", 32'(n_bd[0] - bd0 + n_ur[0] - ur0), 32'd0);
      cs_n[0] = 1'b1;
      #(HALF);
      run_frame(0, 8);

      // Randomized frames, including aborted partial words.
      for (int f = 0; f < 20; f++) begin
         k     = int'($urandom_range(0, 1));
         npush = int'($urandom_range(0, 3));
         for (int p = 0; p < npush; p++) push(k, 8'($urandom));
         if ($urandom_range(0, 3) == 0) nbits = int'($urandom_range(1, 23));
         else nbits = 8 * int'($urandom_range(1, 4));
         run_frame(k, nbits);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave_tx.md
Name: spi_slave_tx

Overview:
MISO transmit path of the SPI slave. Consumes a valid/ready byte stream, normally fed by a `reg_fifo_cas` chain, and serializes it MSB-first onto MISO under master-driven SCLK/CS_N. SCLK and CS_N are oversampled in the CLK_I domain. One-word prefetch holding register; underrun and byte-done status pulses.

Parameters:
WIDTH, 8, bits per SPI word and stream data width
SYNC_STAGES, 2, synchronizer flops on SPI_SCLK_I and SPI_CS_N_I (min 2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = data presented at CS_N fall and shifted on trailing edge; 1 = data shifted on leading edge
IDLE_FILL, {WIDTH{1'b1}}, word transmitted on underrun

Ports:
CLK_I  input  1  system clock, must be at least 8x SCLK frequency
RST_I  input  1  synchronous active-high reset
S_WVALID  input  1  stream data valid
S_WREADY  output  1  holding register empty
S_WDATA  input  WIDTH  stream data
SPI_CS_N_I  input  1  chip select, active low, asynchronous
SPI_SCLK_I  input  1  SPI clock, asynchronous
SPI_MISO_O  output  1  serial data out
SPI_MISO_OE_O  output  1  MISO tristate enable, 1 = drive
BYTE_DONE_O  output  1  one-cycle pulse: full word shifted out
UNDERRUN_O  output  1  one-cycle pulse: IDLE_FILL loaded because hold was empty

Behaviour:
- Clock and reset: one clock, CLK_I. Reset is synchronous and active-high on RST_I.
- Reset values:
  - state = IDLE, hold_valid = 0, shreg = IDLE_FILL, bit_cnt = 0.
  - CS_N synchronizer = 1; SCLK synchronizer = CPOL.
  - SPI_MISO_O = 1, SPI_MISO_OE_O = 0, BYTE_DONE_O = 0, UNDERRUN_O = 0, S_WREADY = 0 during reset.
- Synchronizers and edge detection:
  - Edges are detected on the synchronized signals with one extra register stage.
  - lead = SCLK leaves CPOL; trail = SCLK returns to CPOL.
  - shift_edge = trail if CPHA = 0, lead if CPHA = 1.
- Holding register (one entry):
  - S_WREADY = ~hold_valid, registered.
  - Accept on S_WVALID & S_WREADY: hold <= S_WDATA, hold_valid <= 1.
  - A load from hold clears hold_valid. Accept and load in the same cycle is impossible because S_WREADY = 0 while hold_valid = 1.
- Load operation:
  - shreg <= hold and hold_valid <= 0 if hold_valid.
  - Otherwise shreg <= IDLE_FILL and UNDERRUN_O pulses.
  - bit_cnt <= 0 in both cases.
- FSM states: IDLE, ARM (CPHA = 1 only), SHIFT, WAIT_CS_HIGH.
  - IDLE: on synced CS_N fall: if CPHA = 0, load and go to SHIFT; if CPHA = 1, go to ARM.
  - ARM: on first lead edge, load and go to SHIFT.
  - SHIFT, on shift_edge:
    - if bit_cnt = WIDTH-1: pulse BYTE_DONE_O and load (back-to-back words, no gap cycles);
    - otherwise shreg <= shreg << 1 and bit_cnt++.
  - SHIFT, CS_N synced rise (abort, any bit position): go to IDLE. Partial shreg is discarded, the word counts as consumed, BYTE_DONE_O stays 0, hold is untouched.
  - Any state, CS_N synced rise: go to IDLE.
  - After reset: if synced CS_N = 0, go to WAIT_CS_HIGH; stay there until CS_N is seen high, then go to IDLE. No transaction starts mid-frame.
- Outputs:
  - SPI_MISO_OE_O = 1 in ARM and SHIFT, else 0.
  - SPI_MISO_O = shreg[WIDTH-1], registered. Held at 1 when OE = 0.
  - MISO updates within SYNC_STAGES+2 CLK_I cycles of a pin edge. The master must sample no earlier than half an SCLK period after the shift edge.
- Edge cases:
  - SCLK edges while CS_N is high are ignored.
  - Simultaneous CS_N rise and shift_edge in the same cycle: CS_N rise wins.
  - S_WDATA accepted during an abort cycle is kept for the next frame.
- Reset mid-transfer: hold and shreg are flushed (data lost), then the post-reset rule above applies.

Test Plan:
- CPOL = 0, CPHA = 0. Push 0xA5, 0x3C; CS_N low; 16 SCLK; CS_N high. -> MISO samples 1010_0101 0011_1100; two BYTE_DONE_O pulses; no UNDERRUN_O; S_WREADY = 1 at end.
- Empty stream; CS_N low; 8 SCLK. -> MISO = 0xFF; exactly one UNDERRUN_O pulse at CS_N fall; OE = 1 during frame.
- S_WVALID held high with incrementing data 0x00, 0x01, …; 32 SCLK continuous. -> MISO words 0x00, 0x01, 0x02, 0x03 with no skips or repeats; S_WREADY drops after each accept and re-asserts after each load.
- Queue 0x96, 0x55; CS_N high after 3 SCLK. -> OE = 0 within SYNC_STAGES+3 cycles; no BYTE_DONE_O; next frame sends 0x55.
- CPOL = 1, CPHA = 1. Push 0xC3; 8 SCLK, master samples on rising edge. -> 1100_0011; no MISO change before the first falling edge.
- RST_I asserted for 2 cycles mid-word with CS_N held low. -> outputs at reset values, OE = 0 until CS_N goes high then low again; next frame starts with a clean UNDERRUN_O (hold flushed).
